program_loader: RTL and testbench
=================================

# program_loader

Writes instruction words into the CPU's writable program memory from a byte stream, so a program can be changed without rebuilding the FPGA image. It sits between a byte source (UART receiver or debug bridge) and the program memory's write port. It holds the CPU stalled while a load is in progress. Each instruction is assembled from two bytes, low byte first, and written at consecutive addresses starting from 0.

## Interface
Parameters:
- ADDR_WIDTH, 4, program memory address width; depth = 2^ADDR_WIDTH words
- INSTR_WIDTH, 12, instruction width; legal range 9..16 (two bytes per word)

Ports:
- clk  input  1  single clock; everything is on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; ignored unless state is IDLE
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts a byte this cycle; transfer happens when rx_valid && rx_ready
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  INSTR_WIDTH  write data
- mem_we  output  1  write strobe, one cycle per word
- cpu_hold  output  1  CPU must stall; high from start acceptance until load ends
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse when a load completes successfully
- err  output  1  sticky length error; cleared by reset or the next accepted start

## Operation
- States are IDLE, LEN, LO, HI, WRITE and FINISH.
- IDLE: rx_ready=0. A byte offered here is not consumed. When start=1, clear err, clear the word counter and address, then go to LEN.
- LEN: rx_ready=1. The first accepted byte is N, the word count. N=0 means the full depth, 2^ADDR_WIDTH.
  - If N > 2^ADDR_WIDTH: set err=1 and go to FINISH without any write. done is not pulsed in this case.
  - Otherwise latch N and go to LO.
- LO: rx_ready=1. An accepted byte goes to wdata[7:0]; then go to HI.
- HI: rx_ready=1. An accepted byte supplies wdata[INSTR_WIDTH-1:8] from rx_data[INSTR_WIDTH-9:0]. The unused upper bits are ignored. Then go to WRITE.
- WRITE: mem_we=1 for exactly one cycle, with mem_addr and mem_wdata stable. rx_ready=0.
  - If this is word N: go to FINISH.
  - Otherwise increment mem_addr and go to LO.
- FINISH: cpu_hold drops. done=1 for this cycle only if err=0. Then go to IDLE.
- Address arithmetic: mem_addr is ADDR_WIDTH bits. The word counter is ADDR_WIDTH+1 bits so that N = depth is representable. mem_addr never wraps within one load.
- In LEN, LO and HI, rx_valid=0 stalls the FSM indefinitely with no timeout. cpu_hold stays high during the stall.
- start asserted while busy has no effect.
- Bytes never bypass the FSM. A byte is consumed only on a cycle where both rx_valid and rx_ready are 1.

## Timing
- All outputs are registered or decoded from the state register. There are no combinational paths from any input to any output.
- Reset values: state=IDLE, rx_ready=0, mem_addr=0, mem_wdata=0, mem_we=0, cpu_hold=0, busy=0, done=0, err=0.
- When start is sampled high in IDLE, busy=1 and cpu_hold=1 appear on the next cycle.
- With rx_valid held high, the minimum cost is 3 cycles per word (LO, HI, WRITE). The LEN byte adds 1 cycle and FINISH adds 1 cycle. A full 16-word load takes 1 + 48 + 1 = 50 cycles after start.
- The mem_we pulse comes one cycle after the HI byte is accepted.
- Program memory write port: the write is captured on the same clk edge that ends the mem_we cycle.
- Reset mid-load: the FSM returns to IDLE and cpu_hold=0 on the next cycle. Words already written remain in memory. No done pulse is produced.
- Reset has priority over start. A reset and start sampled high together leave the block in IDLE.

## Test plan
- Reset with rx_valid=1 and start=0 -> all outputs at their reset values, and rx_ready stays 0 for 10 cycles.
- start, then bytes 03, 34,12, 78,56, BC,9A with rx_valid held high:
  - writes 0x234@0, 0x678@1 and 0xABC@2, one mem_we pulse each, 3 cycles apart;
  - done pulses once, 11 cycles after the start cycle;
  - cpu_hold falls together with the done pulse.
- N=00 with 32 data bytes -> 16 writes at addresses 0..15, no wrap, and done pulses.
- N=0x11 with depth 16 -> err=1 and no mem_we, done stays 0, and cpu_hold returns to 0. A following start clears err.
- Random rx_valid gaps and a start pulse mid-load -> identical write sequence to the no-gap case, and the extra start is ignored.
- Reset asserted between the LO and HI bytes of word 1 -> mem_we count is 1, state returns to IDLE, and no done pulse appears.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles two-byte instruction words and
// writes them into program memory from address 0 while stalling the CPU.
module program_loader #(
    parameter int ADDR_WIDTH  = 4,
    parameter int INSTR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   mem_we,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        WRITE,
        FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          len_q, len_d;
    logic                   err_q, err_d;
    logic                   xfer;

    // Every output is a register or a pure decode of the state register.
    assign rx_ready  = (state_q == LEN) || (state_q == LO) || (state_q == HI);
    assign mem_we    = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign cpu_hold  = busy && (state_q != FINISH);
    assign done      = (state_q == FINISH) && !err_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign xfer      = rx_valid && rx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (32'(rx_data) > DEPTH) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        len_d   = (rx_data == 8'd0) ? DEPTH_C : CW'(rx_data);
                        state_d = LO;
                    end
                end
            end
            LO: begin
                if (xfer) begin
                    wdata_d[7:0] = rx_data;
                    state_d      = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    wdata_d[INSTR_WIDTH-1:8] = rx_data[INSTR_WIDTH-9:0];
                    state_d                  = WRITE;
                end
            end
            WRITE: begin
                // Address only advances when another word follows: no wrap.
                if (cnt_q == len_q - CW'(1)) begin
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = LO;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes and
// done pulses; a negedge monitor pops and compares them.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    program_loader #(.ADDR_WIDTH(4), .INSTR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  we_cnt = 0;
    wr_t mon_e;
    int  mon_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_we === 1'b1) begin
                we_cnt++;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h@%0h required=none", mem_wdata, mem_addr);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_addr", int'(mem_addr), mon_e.addr);
                    chk("wr_data", int'(mem_wdata), mon_e.data);
                    if (mon_e.cyc >= 0) chk("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    mon_c = done_q.pop_front();
                    if (mon_c >= 0) chk("done_cycle", cyc, mon_c);
                    chk("hold_at_done", int'(cpu_hold), 0);
                end
            end
        end
    end

    task automatic do_start(output int s);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        s = cyc - 1;
        chk("busy_after_start", int'(busy), 1);
        chk("hold_after_start", int'(cpu_hold), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        int  n;
        logic ok;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            start = pulse && (g == 0);
            @(posedge clk);
            #1 start = 1'b0;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rx_ready;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout actual=rx_ready0 required=rx_ready1 byte=%0h", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic push_wr(input int a, input int d, input int c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        wr_q.push_back(e);
    endtask

    logic [7:0] v3[7];
    int s;
    int we0;
    logic [7:0] lo;
    logic [7:0] hi;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        v3 = '{8'h03, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values, and an offered byte is never taken in IDLE
        @(negedge clk);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_hold", int'(cpu_hold), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_rx_ready", int'(rx_ready), 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;

        // Three words, back-to-back bytes
        do_start(s);
        push_wr(0, 12'h234, s + 4);
        push_wr(1, 12'h678, s + 7);
        push_wr(2, 12'hABC, s + 10);
        done_q.push_back(s + 11);
        for (int i = 0; i < 7; i++) send_byte(v3[i], 0, 1'b0);
        rx_valid = 1'b0;
        wait_idle();
        chk("t2_wr_left", wr_q.size(), 0);
        chk("t2_done_left", done_q.size(), 0);
        chk("t2_err", int'(err), 0);

        // N=0 means full depth; upper HI bits are ignored
        do_start(s);
        for (int i = 0; i < 16; i++) begin
            lo = 8'(i * 17);
            hi = 8'hF0 | 8'(i);
            push_wr(i, (i << 8) | int'(lo), s + 4 + 3 * i);
        end
        done_q.push_back(s + 50);
        send_byte(8'h00, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            lo = 8'(i * 17);
            hi = 8'hF0 | 8'(i);
            send_byte(lo, 0, 1'b0);
            send_byte(hi, 0, 1'b0);
        end
        rx_valid = 1'b0;
        wait_idle();
        chk("t3_wr_left", wr_q.size(), 0);
        chk("t3_done_left", done_q.size(), 0);
        chk("t3_err", int'(err), 0);

        // Length too large: error, no write, no done
        we0 = we_cnt;
        do_start(s);
        send_byte(8'h11, 0, 1'b0);
        rx_valid = 1'b0;
        wait_idle();
        chk("t4_err", int'(err), 1);
        chk("t4_hold", int'(cpu_hold), 0);
        chk("t4_no_write", we_cnt - we0, 0);
        do_start(s);
        chk("t4_err_cleared", int'(err), 0);
        push_wr(0, 12'hDEF, -1);
        done_q.push_back(-1);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hEF, 0, 1'b0);
        send_byte(8'hFD, 0, 1'b0);
        rx_valid = 1'b0;
        wait_idle();
        chk("t4_wr_left", wr_q.size(), 0);
        chk("t4_done_left", done_q.size(), 0);

        // Gaps on rx_valid and a stray start mid-load
        do_start(s);
        push_wr(0, 12'h234, -1);
        push_wr(1, 12'h678, -1);
        push_wr(2, 12'hABC, -1);
        done_q.push_back(-1);
        for (int i = 0; i < 7; i++) begin
            send_byte(v3[i], (i == 3) ? 2 : int'($urandom_range(0, 3)), i == 3);
        end
        rx_valid = 1'b0;
        wait_idle();
        chk("t5_wr_left", wr_q.size(), 0);
        chk("t5_done_left", done_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("t5_stays_idle", int'(busy), 0);

        // Reset between LO and HI of word 1
        we0 = we_cnt;
        do_start(s);
        push_wr(0, 12'h234, -1);
        for (int i = 0; i < 4; i++) send_byte(v3[i], 0, 1'b0);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_hold", int'(cpu_hold), 0);
        chk("t6_rx_ready", int'(rx_ready), 0);
        repeat (5) @(negedge clk);
        chk("t6_we_count", we_cnt - we0, 1);
        chk("t6_wr_left", wr_q.size(), 0);

        chk("final_done_left", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
